ble_adv_scheduler: RTL and testbench
====================================

// Module: ble_adv_scheduler
// PURPOSE
//  Sequences BLE advertising events on top of the PLL-lock wait timing. Once clkLock is high,
//  runs one packet per enabled advertising channel (37 -> 38 -> 39) and repeats every ADV_INTERVAL.
//  For each packet it waits out PLL settling, issues a one-cycle txStart to the packet
//  serializer/FSK modulator and waits for txDone. Between packets it inserts a gap.
//  Sits between clock/PLL control and the packet datapath; drives the channel select to the synth.
// PARAMETERS
//  WAIT_SIZE     24       width of all internal cycle counters (matches `WAIT_SIZE in bleDefines.v)
//  SETTLE_CYCLES 51       cycles waited after event start or channel change before txStart
//  GAP_CYCLES    1_500    idle cycles between packets inside one event
//  ADV_INTERVAL  100_000  cycles from one event start to the next event start
//  TX_TIMEOUT    20_000   maximum cycles waited for txDone before aborting the packet
// PORTS
//  clk         in   1   system clock (PLL output domain)
//  resetn      in   1   async active-low reset
//  clkLock     in   1   PLL lock; low = synchronous abort to IDLE
//  enable      in   1   level; start/continue advertising
//  chanMap     in   3   bit0=ch37, bit1=ch38, bit2=ch39; sampled at each event start
//  txDone      in   1   one-cycle pulse from serializer: packet finished
//  txStart     out  1   one-cycle pulse: begin packet on chanIdx
//  chanIdx     out  6   BLE channel index (37/38/39); stable from SETTLE through TX_WAIT
//  busy        out  1   high in every state except IDLE
//  txErr       out  1   one-cycle pulse on TX_TIMEOUT expiry
//  eventCount  out  16  completed events, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: txStart=0, txErr=0, busy=0, chanIdx=37, eventCount=0, state=IDLE, all counters 0.
//  States: IDLE, SETTLE, TX_REQ, TX_WAIT, GAP, WAIT_IV.
//  - IDLE: if clkLock&&enable&&chanMap!=0, latch chanMap, set chanIdx to lowest enabled channel,
//    clear ivCnt, go SETTLE. If chanMap==0, stay IDLE.
//  - SETTLE: cnt counts 0..SETTLE_CYCLES-1, then TX_REQ. First txStart therefore comes
//    SETTLE_CYCLES+1 cycles after leaving IDLE.
//  - TX_REQ: txStart=1 for exactly this cycle; go TX_WAIT; clear cnt.
//  - TX_WAIT: txDone -> GAP. cnt reaches TX_TIMEOUT-1 without txDone -> txErr pulse, GAP.
//    txDone arriving in any other state is ignored.
//  - GAP: GAP_CYCLES cycles. Then, if a higher enabled channel remains in the latched map,
//    set chanIdx to it and go SETTLE. Otherwise eventCount+=1 and go WAIT_IV.
//  - WAIT_IV: when ivCnt>=ADV_INTERVAL-1, or already beyond it (event longer than interval),
//    behave as IDLE entry: latch map, clear ivCnt, go SETTLE next cycle.
//    If enable==0 or the new chanMap==0 at that moment, go IDLE instead.
//  - ivCnt: free-running from event start in all non-IDLE states; saturates at all-ones.
//  - enable deasserted mid-event: current event completes (incl. gaps), then IDLE.
//  - clkLock low in any state: next cycle state=IDLE, txStart=0, busy=0; chanIdx and
//    eventCount hold; no txErr. An in-flight packet is abandoned (serializer must reset on lock loss).
//  - Counter arithmetic is unsigned WAIT_SIZE. Parameters must be >=1 and < 2**WAIT_SIZE.
//  - All outputs are registered; no combinational input-to-output paths.
// STRUCTURE
//  bleDefines.v: WAIT_SIZE, CH37/CH38/CH39 6-bit constants, state encoding defines.
//  Sub-module ble_wait_timer: load/clear + count + terminal-compare counter (WAIT_SIZE wide).
//  Shared by SETTLE/GAP/TX_WAIT (cnt); ivCnt is a second instance in saturating mode.
//  Channel-advance logic (next enabled bit above current) stays inline in the scheduler.
// TESTING
//  1 reset, clkLock=1, enable=1, chanMap=3'b111, txDone 100 cycles after each txStart ->
//    three txStart pulses with chanIdx 37,38,39; first at cycle 52 after IDLE exit;
//    eventCount=1 after the third gap.
//  2 chanMap=3'b101 -> only 37 and 39 transmitted; second event starts exactly ADV_INTERVAL
//    cycles after the first event starts.
//  3 txDone never asserted -> txErr pulse TX_TIMEOUT cycles after txStart; scheduler continues
//    with the next channel.
//  4 clkLock dropped during TX_WAIT of ch38 -> IDLE next cycle, busy=0, no txErr;
//    relock -> restart at ch37.
//  5 enable dropped during ch37 packet -> 38 and 39 still sent, then IDLE; chanMap=0 -> stays IDLE.
//  6 resetn asserted asynchronously mid-GAP -> all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/ble_adv_scheduler_pkg.sv
// Shared types, constants and channel helpers for the BLE advertising scheduler.
package ble_adv_scheduler_pkg;

  localparam int WAIT_SIZE_DEF = 24;

  localparam logic [5:0] CH37 = 6'd37;
  localparam logic [5:0] CH38 = 6'd38;
  localparam logic [5:0] CH39 = 6'd39;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_TX_REQ  = 3'd2,
    ST_TX_WAIT = 3'd3,
    ST_GAP     = 3'd4,
    ST_WAIT_IV = 3'd5
  } adv_state_e;

  // Lowest enabled channel of a map; caller guarantees map != 0.
  function automatic logic [5:0] first_chan(input logic [2:0] map);
    if (map[0])      return CH37;
    else if (map[1]) return CH38;
    else             return CH39;
  endfunction

  // Next enabled channel above cur: {valid, channel}.
  function automatic logic [6:0] next_chan(input logic [2:0] map, input logic [5:0] cur);
    logic [6:0] r;
    r = '0;
    if (cur == CH37) begin
      if (map[1])      r = {1'b1, CH38};
      else if (map[2]) r = {1'b1, CH39};
    end else if (cur == CH38) begin
      if (map[2])      r = {1'b1, CH39};
    end
    return r;
  endfunction

endpackage

// File: rtl/ble_adv_scheduler_wait_timer.sv
// Clearable up-counter with a terminal compare (count >= term); optional saturation.
module ble_adv_scheduler_wait_timer
  import ble_adv_scheduler_pkg::*;
#(
  parameter int WIDTH = WAIT_SIZE_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_clear,
  input  logic             i_sat,
  input  logic [WIDTH-1:0] i_term,
  output logic             o_hit
);

  logic [WIDTH-1:0] r_count;

  // Count every cycle; clear wins, saturate at all-ones when requested.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                        r_count <= '0;
    else if (i_clear)                   r_count <= '0;
    else if (!(i_sat && (&r_count)))    r_count <= r_count + 1'b1;
  end

  assign o_hit = (r_count >= i_term);

endmodule

// File: rtl/ble_adv_scheduler.sv
// BLE advertising event sequencer: settle, txStart, wait txDone, gap, per channel 37/38/39,
// repeating every ADV_INTERVAL cycles while enabled and the PLL stays locked.
// Handshake: txStart is a one-cycle request; txDone is a one-cycle completion pulse that is
// only honoured in TX_WAIT; any other arrival is dropped.
module ble_adv_scheduler
  import ble_adv_scheduler_pkg::*;
#(
  parameter int WAIT_SIZE     = WAIT_SIZE_DEF,
  parameter int SETTLE_CYCLES = 51,
  parameter int GAP_CYCLES    = 1500,
  parameter int ADV_INTERVAL  = 100000,
  parameter int TX_TIMEOUT    = 20000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clkLock,
  input  logic        enable,
  input  logic [2:0]  chanMap,
  input  logic        txDone,
  output logic        txStart,
  output logic [5:0]  chanIdx,
  output logic        busy,
  output logic        txErr,
  output logic [15:0] eventCount,
  output adv_state_e  o_dbg_state
);

  localparam logic [WAIT_SIZE-1:0] W_SETTLE_T = WAIT_SIZE'(SETTLE_CYCLES - 1);
  localparam logic [WAIT_SIZE-1:0] W_GAP_T    = WAIT_SIZE'(GAP_CYCLES - 1);
  localparam logic [WAIT_SIZE-1:0] W_TO_T     = WAIT_SIZE'(TX_TIMEOUT - 1);
  localparam logic [WAIT_SIZE-1:0] W_IV_T     = WAIT_SIZE'(ADV_INTERVAL - 1);

  adv_state_e     r_state, w_next;
  logic [2:0]     r_map, w_map_next;
  logic [5:0]     r_chan, w_chan_next;
  logic           r_tx_start, r_tx_err, r_busy;
  logic [15:0]    r_evt;
  logic           w_err, w_evt_inc, w_start;
  logic [6:0]     w_adv;
  logic [WAIT_SIZE-1:0] w_cnt_term;
  logic           w_cnt_hit, w_iv_hit, w_cnt_clr, w_iv_clr;

  // Per-state terminal value for the shared packet counter.
  always_comb begin
    w_cnt_term = '0;
    case (r_state)
      ST_SETTLE:  w_cnt_term = W_SETTLE_T;
      ST_TX_WAIT: w_cnt_term = W_TO_T;
      ST_GAP:     w_cnt_term = W_GAP_T;
      default:    w_cnt_term = '0;
    endcase
  end

  // Next-state, channel/map latching and pulse requests.
  always_comb begin
    w_next      = r_state;
    w_map_next  = r_map;
    w_chan_next = r_chan;
    w_err       = 1'b0;
    w_evt_inc   = 1'b0;
    w_start     = 1'b0;
    w_adv       = next_chan(r_map, r_chan);
    if (!clkLock) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (enable && (chanMap != 3'b000)) w_start = 1'b1;
        ST_SETTLE:  if (w_cnt_hit) w_next = ST_TX_REQ;
        ST_TX_REQ:  w_next = ST_TX_WAIT;
        ST_TX_WAIT: begin
          if (txDone) begin
            w_next = ST_GAP;
          end else if (w_cnt_hit) begin
            w_err  = 1'b1;
            w_next = ST_GAP;
          end
        end
        ST_GAP: begin
          if (w_cnt_hit) begin
            if (w_adv[6]) begin
              w_chan_next = w_adv[5:0];
              w_next      = ST_SETTLE;
            end else begin
              // Event complete; with enable gone there is nothing left to wait for.
              w_evt_inc = 1'b1;
              w_next    = enable ? ST_WAIT_IV : ST_IDLE;
            end
          end
        end
        ST_WAIT_IV: begin
          if (w_iv_hit) begin
            if (enable && (chanMap != 3'b000)) w_start = 1'b1;
            else                               w_next  = ST_IDLE;
          end
        end
        default: w_next = ST_IDLE;
      endcase
      if (w_start) begin
        w_map_next  = chanMap;
        w_chan_next = first_chan(chanMap);
        w_next      = ST_SETTLE;
      end
    end
  end

  // Packet counter restarts on entry to SETTLE/TX_REQ/GAP; it keeps running from
  // TX_REQ into TX_WAIT so the timeout is measured from the txStart cycle.
  assign w_cnt_clr = ((w_next != r_state) && (w_next != ST_TX_WAIT)) || (w_next == ST_IDLE);
  // Interval counter restarts at each event start and is held at zero while idle.
  assign w_iv_clr  = w_start || (w_next == ST_IDLE);

  ble_adv_scheduler_wait_timer #(.WIDTH(WAIT_SIZE)) u_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .i_clear (w_cnt_clr),
    .i_sat   (1'b0),
    .i_term  (w_cnt_term),
    .o_hit   (w_cnt_hit)
  );

  ble_adv_scheduler_wait_timer #(.WIDTH(WAIT_SIZE)) u_iv (
    .clk     (clk),
    .resetn  (resetn),
    .i_clear (w_iv_clr),
    .i_sat   (1'b1),
    .i_term  (W_IV_T),
    .o_hit   (w_iv_hit)
  );

  // State and registered outputs; txStart/busy are derived from the next state so they
  // line up with TX_REQ / non-IDLE cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_map      <= 3'b000;
      r_chan     <= CH37;
      r_tx_start <= 1'b0;
      r_tx_err   <= 1'b0;
      r_busy     <= 1'b0;
      r_evt      <= 16'd0;
    end else begin
      r_state    <= w_next;
      r_map      <= w_map_next;
      r_chan     <= w_chan_next;
      r_tx_start <= (w_next == ST_TX_REQ);
      r_tx_err   <= w_err;
      r_busy     <= (w_next != ST_IDLE);
      if (w_evt_inc) r_evt <= r_evt + 16'd1;
    end
  end

  assign txStart     = r_tx_start;
  assign chanIdx     = r_chan;
  assign busy        = r_busy;
  assign txErr       = r_tx_err;
  assign eventCount  = r_evt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ble_adv_scheduler.sv
// Self-checking bench for ble_adv_scheduler (shortened gap/interval/timeout parameters).
module tb_ble_adv_scheduler;
  import ble_adv_scheduler_pkg::*;

  localparam int P_WAIT   = 24;
  localparam int P_SETTLE = 51;
  localparam int P_GAP    = 20;
  localparam int P_ADV    = 1500;
  localparam int P_TO     = 300;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        clkLock = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  chanMap = 3'b000;
  logic        txDone = 1'b0;
  logic        txStart, busy, txErr;
  logic [5:0]  chanIdx;
  logic [15:0] eventCount;
  adv_state_e  dbg_state;

  logic [5:0] exp_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, tx_count = 0, err_count = 0;
  int last_start_cyc = 0, last_err_cyc = 0;
  int resp_delay = 0, done_cnt = 0;

  typedef struct {
    logic [2:0] map;
    int         n;
    logic [5:0] ch0, ch1, ch2;
  } vec_t;
  vec_t vecs[8];

  ble_adv_scheduler #(
    .WAIT_SIZE(P_WAIT), .SETTLE_CYCLES(P_SETTLE), .GAP_CYCLES(P_GAP),
    .ADV_INTERVAL(P_ADV), .TX_TIMEOUT(P_TO)
  ) dut (
    .clk(clk), .resetn(resetn), .clkLock(clkLock), .enable(enable), .chanMap(chanMap),
    .txDone(txDone), .txStart(txStart), .chanIdx(chanIdx), .busy(busy), .txErr(txErr),
    .eventCount(eventCount), .o_dbg_state(dbg_state)
  );

  // Clock and cycle index.
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every txStart pops the expected channel.
  always @(negedge clk) begin
    if (resetn) begin
      if (txStart) begin
        tx_count++;
        last_start_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_txstart", int'(chanIdx), 0);
        else check("tx_chan", int'(chanIdx), int'(exp_q.pop_front()));
      end
      if (txErr) begin
        err_count++;
        last_err_cyc = cyc;
      end
    end
  end

  // Serializer model: txDone resp_delay cycles after txStart (0 = never).
  always @(negedge clk) begin
    txDone = 1'b0;
    if (txStart && resetn) done_cnt = resp_delay;
    else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) txDone = 1'b1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_tx(input int n, input int budget, input string name);
    int k = 0;
    while (tx_count < n && k < budget) begin step(); k++; end
    check({name, "_tx_count_reached"}, int'(tx_count >= n), 1);
  endtask

  task automatic wait_busy(input logic v, input int budget, input string name);
    int k = 0;
    while (busy !== v && k < budget) begin step(); k++; end
    check({name, "_busy_level"}, int'(busy), int'(v));
  endtask

  task automatic wait_evt(input int n, input int budget, input string name);
    int k = 0;
    while (int'(eventCount) < n && k < budget) begin step(); k++; end
    check({name, "_event_count"}, int'(eventCount), n);
  endtask

  task automatic wait_err(input int n, input int budget, input string name);
    int k = 0;
    while (err_count < n && k < budget) begin step(); k++; end
    check({name, "_err_count_reached"}, int'(err_count >= n), 1);
  endtask

  task automatic wait_state(input adv_state_e s, input int budget, input string name);
    int k = 0;
    while (dbg_state != s && k < budget) begin step(); k++; end
    check({name, "_state"}, int'(dbg_state), int'(s));
  endtask

  initial begin
    int b_cyc, t1, t3, e_cyc, base_tx, base_evt;

    vecs[0] = '{3'b001, 1, CH37, 6'd0, 6'd0};
    vecs[1] = '{3'b010, 1, CH38, 6'd0, 6'd0};
    vecs[2] = '{3'b011, 2, CH37, CH38, 6'd0};
    vecs[3] = '{3'b100, 1, CH39, 6'd0, 6'd0};
    vecs[4] = '{3'b101, 2, CH37, CH39, 6'd0};
    vecs[5] = '{3'b110, 2, CH38, CH39, 6'd0};
    vecs[6] = '{3'b111, 3, CH37, CH38, CH39};
    vecs[7] = '{3'b000, 0, 6'd0, 6'd0, 6'd0};

    // Reset values
    repeat (3) step();
    check("rst_txStart", int'(txStart), 0);
    check("rst_txErr", int'(txErr), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_chanIdx", int'(chanIdx), 37);
    check("rst_eventCount", int'(eventCount), 0);
    check("rst_state", int'(dbg_state), int'(ST_IDLE));
    resetn = 1'b1;
    step();

    // 1: all three channels, first txStart 52 cycles after the IDLE-exit cycle
    resp_delay = 100;
    exp_q.push_back(CH37); exp_q.push_back(CH38); exp_q.push_back(CH39);
    clkLock = 1'b1; enable = 1'b1; chanMap = 3'b111;
    wait_busy(1'b1, 20, "t1_start");
    b_cyc = cyc;
    wait_tx(1, 100, "t1_first");
    t1 = last_start_cyc;
    check("t1_first_tx_latency", t1 - b_cyc, P_SETTLE);
    wait_tx(3, 700, "t1_third");
    t3 = last_start_cyc;
    wait_evt(1, 300, "t1");
    e_cyc = cyc;
    check("t1_evt_after_gap", e_cyc - t3, 100 + 1 + P_GAP);
    check("t1_tx_total", tx_count, 3);

    // 2: map 101 on the next event, exactly one interval later
    chanMap = 3'b101;
    exp_q.push_back(CH37); exp_q.push_back(CH39);
    wait_tx(4, 1600, "t2_first");
    check("t2_event_interval", last_start_cyc - t1, P_ADV);
    wait_tx(5, 400, "t2_second");
    wait_evt(2, 400, "t2");
    enable = 1'b0;
    wait_busy(1'b0, 1700, "t2_idle");
    check("t2_tx_total", tx_count, 5);
    check("t2_no_err", err_count, 0);

    // 3: no txDone -> txErr TX_TIMEOUT cycles after txStart, then next channel
    resp_delay = 0;
    exp_q.push_back(CH37); exp_q.push_back(CH38); exp_q.push_back(CH39);
    chanMap = 3'b111; enable = 1'b1;
    wait_tx(6, 200, "t3_first");
    t1 = last_start_cyc;
    wait_err(1, P_TO + 50, "t3_err");
    check("t3_err_latency", last_err_cyc - t1, P_TO);
    step();
    check("t3_err_one_cycle", int'(txErr), 0);
    wait_tx(8, 1200, "t3_rest");
    enable = 1'b0;
    wait_busy(1'b0, 1000, "t3_idle");
    check("t3_err_total", err_count, 3);
    check("t3_evt", int'(eventCount), 3);

    // 4: lock lost during ch38 TX_WAIT, relock restarts at ch37
    resp_delay = 100;
    exp_q.push_back(CH37); exp_q.push_back(CH38);
    enable = 1'b1;
    wait_tx(10, 600, "t4_ch38");
    repeat (10) step();
    check("t4_in_tx_wait", int'(dbg_state), int'(ST_TX_WAIT));
    clkLock = 1'b0;
    step();
    check("t4_state_idle", int'(dbg_state), int'(ST_IDLE));
    check("t4_busy_low", int'(busy), 0);
    check("t4_txStart_low", int'(txStart), 0);
    check("t4_chan_hold", int'(chanIdx), 38);
    check("t4_evt_hold", int'(eventCount), 3);
    repeat (150) step();
    check("t4_no_err", err_count, 3);
    check("t4_no_tx", tx_count, 10);
    exp_q.push_back(CH37); exp_q.push_back(CH38); exp_q.push_back(CH39);
    clkLock = 1'b1;
    wait_evt(4, 1000, "t4_relock");
    enable = 1'b0;
    wait_busy(1'b0, 2000, "t4_idle");
    check("t4_tx_total", tx_count, 13);

    // 5: enable dropped during ch37 packet, event still completes
    exp_q.push_back(CH37); exp_q.push_back(CH38); exp_q.push_back(CH39);
    enable = 1'b1;
    wait_tx(14, 200, "t5_ch37");
    enable = 1'b0;
    wait_busy(1'b0, 1000, "t5_idle");
    check("t5_tx_total", tx_count, 16);
    check("t5_evt", int'(eventCount), 5);

    // Table: one event per channel map (map 0 must stay idle)
    resp_delay = 10;
    for (int i = 0; i < 8; i++) begin
      base_tx  = tx_count;
      base_evt = int'(eventCount);
      chanMap  = vecs[i].map;
      if (vecs[i].n > 0) exp_q.push_back(vecs[i].ch0);
      if (vecs[i].n > 1) exp_q.push_back(vecs[i].ch1);
      if (vecs[i].n > 2) exp_q.push_back(vecs[i].ch2);
      enable = 1'b1;
      if (vecs[i].n > 0) begin
        wait_busy(1'b1, 20, "vec_start");
        enable = 1'b0;
        wait_busy(1'b0, 1000, "vec_end");
      end else begin
        repeat (60) step();
        check("vec_map0_busy", int'(busy), 0);
        enable = 1'b0;
      end
      check("vec_tx_delta", tx_count - base_tx, vecs[i].n);
      check("vec_evt_delta", int'(eventCount) - base_evt, (vecs[i].n > 0) ? 1 : 0);
    end
    check("exp_q_drained", exp_q.size(), 0);

    // 6: asynchronous reset in the middle of the ch38 gap
    exp_q.push_back(CH37); exp_q.push_back(CH38); exp_q.push_back(CH39);
    base_tx = tx_count;
    chanMap = 3'b111; enable = 1'b1;
    wait_tx(base_tx + 2, 400, "t6_ch38");
    wait_state(ST_GAP, 100, "t6_gap");
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_busy", int'(busy), 0);
    check("t6_txStart", int'(txStart), 0);
    check("t6_txErr", int'(txErr), 0);
    check("t6_chanIdx", int'(chanIdx), 37);
    check("t6_eventCount", int'(eventCount), 0);
    check("t6_state", int'(dbg_state), int'(ST_IDLE));
    exp_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
